// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared widths, sweep constants and FSM state encoding for ram_reader
package ram_reader_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam int LAST_ADDR = (1 << ADDR_W_DEF) - 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, HOLD, DONE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ram_reader_dwell_counter.sv
// dwell_counter: loadable down-counter that sticks at zero and flags it
module dwell_counter #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count;
  // load wins over counting; counting stops once zero is reached
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) count <= '0;
    else count <= load ? value : (en && !zero) ? count - 1'b1 : count;
  assign zero = count == '0;
endmodule

// File: rtl/ram_reader.sv
// ram_reader: sweeps ram32x4 addresses and holds each word on the display outputs; optional RAM_READER_MATCH_EN adds match counting
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RD_LATENCY   = 1,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
`ifdef RAM_READER_MATCH_EN
  input  logic [DATA_W-1:0] match_value,
  output logic [ADDR_W:0]   match_count,
`endif
  output logic              done
);
  localparam int DW_W  = cnt_w(DWELL_CYCLES);
  localparam int LAT_W = cnt_w(RD_LATENCY);
  state_t state;
  logic go_issue, lat_zero, dw_zero, last;
  assign ram_wren = 1'b0;
  assign last = &ram_address;
  // the latency count is loaded on the way into ISSUE so ISSUE itself already counts as one latency clock
  always_comb go_issue = !stop && ((state == IDLE || state == DONE) ? start : (state == HOLD && dw_zero && (!last || continuous)));
  dwell_counter #(.W(LAT_W)) u_lat (
    .clock(clock),
    .resetn(resetn),
    .load(go_issue),
    .en(state == ISSUE || state == WAIT),
    .value(LAT_W'(RD_LATENCY - 1)),
    .zero(lat_zero)
  );
  dwell_counter #(.W(DW_W)) u_dwell (
    .clock(clock),
    .resetn(resetn),
    .load(state == CAPTURE),
    .en(state == HOLD),
    .value(DW_W'(DWELL_CYCLES - 1)),
    .zero(dw_zero)
  );
  // sweep sequencer: owns state, RAM address and every registered output; stop overrides everything
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state       <= IDLE;
      ram_address <= '0;
      out_address <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef RAM_READER_MATCH_EN
      match_count <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            ram_address <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= ISSUE;
`ifdef RAM_READER_MATCH_EN
            match_count <= '0;
`endif
          end
          ISSUE: state <= lat_zero ? CAPTURE : WAIT;
          WAIT: if (lat_zero) state <= CAPTURE;
          CAPTURE: begin
            out_data    <= ram_q;
            out_address <= ram_address;
            out_valid   <= 1'b1;
            state       <= HOLD;
`ifdef RAM_READER_MATCH_EN
            if (ram_q == match_value && !match_count[ADDR_W]) match_count <= match_count + 1'b1;
`endif
          end
          HOLD: if (dw_zero) begin
            if (!last || continuous) begin
              ram_address <= ram_address + 1'b1;
              state       <= ISSUE;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule
